// File: rtl/npu_queue_unit.sv
// NPU command queue unit: config, input and output FIFOs between the CPU execute
// stage and the NPU, with CPU backpressure and config-before-data ordering.

module npu_queue_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic [CNT_W-1:0]  count_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full, empty, push_ok, pop_ok;

    // Full/empty depend only on the registered count, so a same-cycle pop never
    // frees room for a push and a same-cycle push never feeds a pop.
    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push_i & ~full;
    assign pop_ok  = pop_i & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = empty ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;
endmodule

module npu_queue_unit #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 4
) (
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic              iNpuCfgOp,
    input  logic              iNpuEnqOp,
    input  logic              iNpuDeqOp,
    input  logic [DATA_W-1:0] iData,
    output logic [DATA_W-1:0] oData,
    output logic              oStall,
    output logic              oCfgValid,
    output logic [DATA_W-1:0] oCfgData,
    input  logic              iCfgReady,
    output logic              oInValid,
    output logic [DATA_W-1:0] oInData,
    input  logic              iInReady,
    input  logic              iOutValid,
    input  logic [DATA_W-1:0] iOutData,
    output logic              oOutReady,
    output logic [CNT_W-1:0]  oInCount,
    output logic [CNT_W-1:0]  oOutCount
);
    logic [CNT_W-1:0] cfg_count;
    logic             cfg_full, cfg_empty, in_full, in_empty, out_full, out_empty;
    logic             cfg_sel, enq_sel, deq_sel;
    logic             cfg_push, in_push, out_pop;

    assign cfg_full  = (cfg_count == CNT_W'(DEPTH));
    assign cfg_empty = (cfg_count == '0);
    assign in_full   = (oInCount == CNT_W'(DEPTH));
    assign in_empty  = (oInCount == '0);
    assign out_full  = (oOutCount == CNT_W'(DEPTH));
    assign out_empty = (oOutCount == '0);

    // Only the highest-priority op is serviced: Cfg > Enq > Deq.
    assign cfg_sel = iNpuCfgOp;
    assign enq_sel = iNpuEnqOp & ~iNpuCfgOp;
    assign deq_sel = iNpuDeqOp & ~iNpuCfgOp & ~iNpuEnqOp;

    always_comb begin
        oStall = 1'b0;
        if (cfg_sel)      oStall = cfg_full;
        else if (enq_sel) oStall = in_full;
        else if (deq_sel) oStall = out_empty;
        oStall = oStall & iRst_n;
    end

    assign cfg_push  = cfg_sel & ~cfg_full;
    assign in_push   = enq_sel & ~in_full;
    assign out_pop   = deq_sel & ~out_empty;

    // Input data is held back while any config word is still pending.
    assign oCfgValid = ~cfg_empty;
    assign oInValid  = ~in_empty & cfg_empty;
    assign oOutReady = iRst_n & ~out_full;

    npu_queue_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_cfg_fifo (
        .clk_i   (iClk),
        .rst_ni  (iRst_n),
        .push_i  (cfg_push),
        .pop_i   (oCfgValid & iCfgReady),
        .wdata_i (iData),
        .rdata_o (oCfgData),
        .count_o (cfg_count)
    );

    npu_queue_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_in_fifo (
        .clk_i   (iClk),
        .rst_ni  (iRst_n),
        .push_i  (in_push),
        .pop_i   (oInValid & iInReady),
        .wdata_i (iData),
        .rdata_o (oInData),
        .count_o (oInCount)
    );

    npu_queue_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_out_fifo (
        .clk_i   (iClk),
        .rst_ni  (iRst_n),
        .push_i  (iOutValid & oOutReady),
        .pop_i   (out_pop),
        .wdata_i (iOutData),
        .rdata_o (oData),
        .count_o (oOutCount)
    );
endmodule

// File: tb/tb_npu_queue_unit.sv
// Directed bench for npu_queue_unit: reset, ordering, full/empty stalls,
// output FIFO wrap with simultaneous push/pop, and op priority.

module tb_npu_queue_unit;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 4;

    logic              iClk = 1'b0;
    logic              iRst_n;
    logic              iNpuCfgOp, iNpuEnqOp, iNpuDeqOp;
    logic [DATA_W-1:0] iData;
    logic [DATA_W-1:0] oData;
    logic              oStall;
    logic              oCfgValid;
    logic [DATA_W-1:0] oCfgData;
    logic              iCfgReady;
    logic              oInValid;
    logic [DATA_W-1:0] oInData;
    logic              iInReady;
    logic              iOutValid;
    logic [DATA_W-1:0] iOutData;
    logic              oOutReady;
    logic [CNT_W-1:0]  oInCount;
    logic [CNT_W-1:0]  oOutCount;

    int total = 0;
    int bad   = 0;
    logic [DATA_W-1:0] exp_q[$];

    npu_queue_unit #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .iClk      (iClk),
        .iRst_n    (iRst_n),
        .iNpuCfgOp (iNpuCfgOp),
        .iNpuEnqOp (iNpuEnqOp),
        .iNpuDeqOp (iNpuDeqOp),
        .iData     (iData),
        .oData     (oData),
        .oStall    (oStall),
        .oCfgValid (oCfgValid),
        .oCfgData  (oCfgData),
        .iCfgReady (iCfgReady),
        .oInValid  (oInValid),
        .oInData   (oInData),
        .iInReady  (iInReady),
        .iOutValid (iOutValid),
        .iOutData  (iOutData),
        .oOutReady (oOutReady),
        .oInCount  (oInCount),
        .oOutCount (oOutCount)
    );

    always #5 iClk = ~iClk;

    task automatic cycle();
        @(posedge iClk);
        #1;
    endtask

    task automatic idle();
        iNpuCfgOp = 1'b0;
        iNpuEnqOp = 1'b0;
        iNpuDeqOp = 1'b0;
        iData     = '0;
        iCfgReady = 1'b0;
        iInReady  = 1'b0;
        iOutValid = 1'b0;
        iOutData  = '0;
    endtask

    task automatic test_reset();
        idle();
        iRst_n = 1'b0;
        #12;
        total++; if (oStall !== 1'b0 || oOutReady !== 1'b0 || oInCount !== '0)
            begin bad++; $display("FAIL reset_init stall=%b ordy=%b incnt=%0d want 0 0 0", oStall, oOutReady, oInCount); end
        iRst_n = 1'b1;
        cycle();
        for (int i = 0; i < 3; i++) begin
            iNpuEnqOp = 1'b1; iData = 32'h30 + i;
            cycle();
        end
        iNpuEnqOp = 1'b0;
        #1;
        total++; if (oInCount !== 4'd3 || oInValid !== 1'b1)
            begin bad++; $display("FAIL reset_prefill cnt=%0d valid=%b want 3 1", oInCount, oInValid); end
        iNpuDeqOp = 1'b1;
        #2 iRst_n = 1'b0;
        #1;
        total++; if (oInValid !== 1'b0 || oCfgValid !== 1'b0 || oInCount !== '0 || oOutCount !== '0)
            begin bad++; $display("FAIL reset_mid valid=%b%b counts=%0d/%0d want 00 0/0", oInValid, oCfgValid, oInCount, oOutCount); end
        total++; if (oStall !== 1'b0 || oOutReady !== 1'b0 || oInData !== '0 || oData !== '0)
            begin bad++; $display("FAIL reset_mid_out stall=%b ordy=%b indata=%h data=%h want 0 0 0 0", oStall, oOutReady, oInData, oData); end
        idle();
        @(negedge iClk);
        iRst_n = 1'b1;
        cycle();
        total++; if (oOutReady !== 1'b1 || oInCount !== '0 || oInValid !== 1'b0)
            begin bad++; $display("FAIL reset_release ordy=%b cnt=%0d valid=%b want 1 0 0", oOutReady, oInCount, oInValid); end
    endtask

    task automatic test_ordering();
        idle();
        iNpuCfgOp = 1'b1; iData = 32'hA;
        #1;
        total++; if (oStall !== 1'b0)
            begin bad++; $display("FAIL order_cfg_stall got=%b want 0", oStall); end
        cycle();
        iNpuCfgOp = 1'b0; iNpuEnqOp = 1'b1; iData = 32'h1;
        cycle();
        iData = 32'h2;
        cycle();
        idle();
        #1;
        total++; if (oInValid !== 1'b0 || oInCount !== 4'd2 || oCfgValid !== 1'b1 || oCfgData !== 32'hA)
            begin bad++; $display("FAIL order_hold inv=%b cnt=%0d cfgv=%b cfgd=%h want 0 2 1 a", oInValid, oInCount, oCfgValid, oCfgData); end
        iCfgReady = 1'b1;
        cycle();
        iCfgReady = 1'b0;
        #1;
        total++; if (oCfgValid !== 1'b0 || oInValid !== 1'b1 || oInData !== 32'h1)
            begin bad++; $display("FAIL order_release cfgv=%b inv=%b ind=%h want 0 1 1", oCfgValid, oInValid, oInData); end
        iInReady = 1'b1;
        cycle();
        total++; if (oInData !== 32'h2)
            begin bad++; $display("FAIL order_second got=%h want 2", oInData); end
        cycle();
        iInReady = 1'b0;
        total++; if (oInValid !== 1'b0 || oInData !== '0 || oInCount !== '0)
            begin bad++; $display("FAIL order_drained inv=%b ind=%h cnt=%0d want 0 0 0", oInValid, oInData, oInCount); end
    endtask

    task automatic test_full_input();
        idle();
        for (int i = 0; i < DEPTH; i++) begin
            iNpuEnqOp = 1'b1; iData = 32'h100 + i;
            #1;
            total++; if (oStall !== 1'b0)
                begin bad++; $display("FAIL full_fill_stall idx=%0d got=%b want 0", i, oStall); end
            cycle();
        end
        iData = 32'hDEAD;
        #1;
        total++; if (oInCount !== 4'd8 || oStall !== 1'b1)
            begin bad++; $display("FAIL full_ninth cnt=%0d stall=%b want 8 1", oInCount, oStall); end
        cycle();
        total++; if (oInCount !== 4'd8)
            begin bad++; $display("FAIL full_refused cnt=%0d want 8", oInCount); end
        iInReady = 1'b1;
        #1;
        total++; if (oStall !== 1'b1 || oInValid !== 1'b1)
            begin bad++; $display("FAIL full_pop_stall stall=%b inv=%b want 1 1", oStall, oInValid); end
        cycle();
        iNpuEnqOp = 1'b0;
        total++; if (oInCount !== 4'd7)
            begin bad++; $display("FAIL full_after_pop cnt=%0d want 7", oInCount); end
        for (int i = 1; i < DEPTH; i++) begin
            total++; if (oInData !== 32'h100 + i)
                begin bad++; $display("FAIL full_drain idx=%0d got=%h want %h", i, oInData, 32'h100 + i); end
            cycle();
        end
        iInReady = 1'b0;
        total++; if (oInCount !== '0)
            begin bad++; $display("FAIL full_drained cnt=%0d want 0", oInCount); end
    endtask

    task automatic test_empty_deq();
        idle();
        iNpuDeqOp = 1'b1;
        #1;
        total++; if (oStall !== 1'b1 || oData !== '0)
            begin bad++; $display("FAIL deq_empty stall=%b data=%h want 1 0", oStall, oData); end
        iOutValid = 1'b1; iOutData = 32'h55;
        cycle();
        iOutValid = 1'b0;
        #1;
        total++; if (oStall !== 1'b0 || oData !== 32'h55 || oOutCount !== 4'd1)
            begin bad++; $display("FAIL deq_ready stall=%b data=%h cnt=%0d want 0 55 1", oStall, oData, oOutCount); end
        cycle();
        iNpuDeqOp = 1'b0;
        total++; if (oOutCount !== '0)
            begin bad++; $display("FAIL deq_popped cnt=%0d want 0", oOutCount); end
    endtask

    task automatic test_back_to_back();
        idle();
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            iOutValid = 1'b1; iOutData = 32'h200 + i;
            exp_q.push_back(32'h200 + i);
            cycle();
        end
        total++; if (oOutCount !== 4'd4)
            begin bad++; $display("FAIL b2b_prefill cnt=%0d want 4", oOutCount); end
        iNpuDeqOp = 1'b1;
        for (int i = 4; i < 12; i++) begin
            iOutData = 32'h200 + i;
            exp_q.push_back(32'h200 + i);
            #1;
            total++; if (oData !== exp_q[0] || oStall !== 1'b0)
                begin bad++; $display("FAIL b2b_simul idx=%0d data=%h stall=%b want %h 0", i, oData, oStall, exp_q[0]); end
            void'(exp_q.pop_front());
            cycle();
            total++; if (oOutCount !== 4'd4)
                begin bad++; $display("FAIL b2b_count idx=%0d cnt=%0d want 4", i, oOutCount); end
        end
        iOutValid = 1'b0;
        while (exp_q.size() > 0) begin
            #1;
            total++; if (oData !== exp_q[0])
                begin bad++; $display("FAIL b2b_drain data=%h want %h", oData, exp_q[0]); end
            void'(exp_q.pop_front());
            cycle();
        end
        iNpuDeqOp = 1'b0;
        total++; if (oOutCount !== '0)
            begin bad++; $display("FAIL b2b_drained cnt=%0d want 0", oOutCount); end
    endtask

    task automatic test_priority();
        idle();
        iOutValid = 1'b1; iOutData = 32'h77;
        cycle();
        iOutValid = 1'b0;
        iNpuCfgOp = 1'b1; iNpuDeqOp = 1'b1; iData = 32'hC1;
        #1;
        total++; if (oStall !== 1'b0)
            begin bad++; $display("FAIL prio_stall got=%b want 0", oStall); end
        cycle();
        idle();
        #1;
        total++; if (oOutCount !== 4'd1 || oCfgValid !== 1'b1 || oCfgData !== 32'hC1 || oData !== 32'h77)
            begin bad++; $display("FAIL prio_result ocnt=%0d cfgv=%b cfgd=%h data=%h want 1 1 c1 77", oOutCount, oCfgValid, oCfgData, oData); end
        iCfgReady = 1'b1; iNpuDeqOp = 1'b1;
        cycle();
        idle();
        total++; if (oOutCount !== '0 || oCfgValid !== 1'b0)
            begin bad++; $display("FAIL prio_cleanup ocnt=%0d cfgv=%b want 0 0", oOutCount, oCfgValid); end
    endtask

    task automatic test_cfg_full();
        idle();
        for (int i = 0; i < DEPTH; i++) begin
            iNpuCfgOp = 1'b1; iData = 32'h400 + i;
            cycle();
        end
        iNpuEnqOp = 1'b1;
        #1;
        total++; if (oStall !== 1'b1)
            begin bad++; $display("FAIL cfg_full_stall got=%b want 1", oStall); end
        cycle();
        idle();
        iCfgReady = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            total++; if (oCfgData !== 32'h400 + i)
                begin bad++; $display("FAIL cfg_full_drain idx=%0d got=%h want %h", i, oCfgData, 32'h400 + i); end
            cycle();
        end
        idle();
        total++; if (oCfgValid !== 1'b0 || oInCount !== '0)
            begin bad++; $display("FAIL cfg_full_end cfgv=%b incnt=%0d want 0 0", oCfgValid, oInCount); end
    endtask

    initial begin
        test_reset();
        test_ordering();
        test_full_input();
        test_empty_deq();
        test_back_to_back();
        test_priority();
        test_cfg_full();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
